// File: rtl/trng_pkg.sv
// Shared types and default sizing for the TRNG collector slice.
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    COLLECT = 2'd2,
    STALL   = 2'd3
  } trng_state_t;

  localparam int TRNG_WORD_WIDTH = 32;
  localparam int TRNG_WARMUP     = 4;
  localparam int TRNG_REP_LIMIT  = 16;

endpackage

// File: rtl/trng_vn_corrector.sv
// Von Neumann corrector: pairs raw samples, emits the first bit of a 01/10 pair.
module trng_vn_corrector (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sample_valid,
  input  logic sample,
  output logic bit_valid,
  output logic vn_bit
);

  logic pair_q;
  logic first_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q  <= 1'b0;
      first_q <= 1'b0;
    end else if (clear) begin
      pair_q <= 1'b0;
    end else if (sample_valid) begin
      if (!pair_q) first_q <= sample;
      pair_q <= !pair_q;
    end
  end

  // Pair (1,0) yields 1 and (0,1) yields 0, so the output is simply the first bit.
  assign bit_valid = sample_valid && !clear && pair_q && (first_q != sample);
  assign vn_bit    = first_q;

endmodule

// File: rtl/trng_collector.sv
// TRNG consumer: warm-up, von Neumann correction, word packing, valid/ready output.
// Optional repetition-count health test enabled by defining TRNG_HEALTH_EN.
module trng_collector
  import trng_pkg::*;
#(
  parameter int WIDTH         = TRNG_WORD_WIDTH,
  parameter int WARMUP_CYCLES = TRNG_WARMUP,
  parameter int REP_LIMIT     = TRNG_REP_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  output logic             trng_en_o,
  input  logic             trng_in,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             error_o
);

  localparam int WCW = (WARMUP_CYCLES > 2) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int BCW = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > 64 || WARMUP_CYCLES < 2 || REP_LIMIT < 2) begin : g_bad_params
    $error("trng_collector: parameter out of range");
  end

  trng_state_t      state_q;
  logic [WCW-1:0]   warm_cnt;
  logic [BCW-1:0]   bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             vn_valid;
  logic             vn_bit;
  logic             vn_clear;
  logic             health_trip;

  assign vn_clear = (state_q != COLLECT) || !enable_i || health_trip;

  trng_vn_corrector u_vn (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (vn_clear),
    .sample_valid (state_q == COLLECT),
    .sample       (trng_in),
    .bit_valid    (vn_valid),
    .vn_bit       (vn_bit)
  );

`ifdef TRNG_HEALTH_EN
  localparam int RCW = $clog2(REP_LIMIT + 1);

  logic [RCW-1:0] run_cnt;
  logic [RCW-1:0] run_next;
  logic           last_q;
  logic           in_test;

  assign in_test = enable_i && (state_q == COLLECT || state_q == STALL);

  always_comb begin
    run_next = RCW'(1);
    if (run_cnt != '0 && trng_in == last_q) run_next = run_cnt + 1'b1;
  end

  assign health_trip = in_test && (run_next == RCW'(REP_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
      last_q  <= 1'b0;
    end else if (in_test && !health_trip) begin
      run_cnt <= run_next;
      last_q  <= trng_in;
    end else begin
      run_cnt <= '0;
    end
  end

  // Sticky until software drops enable, which also lets IDLE be left again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           error_o <= 1'b0;
    else if (!enable_i)   error_o <= 1'b0;
    else if (health_trip) error_o <= 1'b1;
  end
`else
  assign health_trip = 1'b0;
  assign error_o     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      trng_en_o <= 1'b0;
      valid_o   <= 1'b0;
      data_o    <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      warm_cnt  <= '0;
    end else begin
      if (valid_o && ready_i) valid_o <= 1'b0;

      // Abort drops the partial word but leaves any unread word on data_o.
      if (state_q != IDLE && (!enable_i || health_trip)) begin
        state_q   <= IDLE;
        trng_en_o <= 1'b0;
        bit_cnt   <= '0;
        shreg     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (enable_i && !error_o) begin
              state_q   <= WARMUP;
              trng_en_o <= 1'b1;
              warm_cnt  <= '0;
            end
          end
          WARMUP: begin
            if (warm_cnt == WCW'(WARMUP_CYCLES - 1)) state_q <= COLLECT;
            else                                      warm_cnt <= warm_cnt + 1'b1;
          end
          COLLECT: begin
            if (vn_valid) begin
              if (bit_cnt == BCW'(WIDTH - 1)) begin
                if (!valid_o || ready_i) begin
                  data_o  <= {shreg[WIDTH-2:0], vn_bit};
                  valid_o <= 1'b1;
                  bit_cnt <= '0;
                end else begin
                  shreg   <= {shreg[WIDTH-2:0], vn_bit};
                  bit_cnt <= BCW'(WIDTH);
                  state_q <= STALL;
                end
              end else begin
                shreg   <= {shreg[WIDTH-2:0], vn_bit};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          STALL: begin
            if (ready_i) begin
              data_o  <= shreg;
              valid_o <= 1'b1;
              bit_cnt <= '0;
              state_q <= COLLECT;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector (WIDTH=8): word-level scoreboard plus literal checks.
module tb_trng_collector;

  localparam int W = 8;
`ifdef TRNG_HEALTH_EN
  localparam bit HEALTH = 1'b1;
`else
  localparam bit HEALTH = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable_i = 1'b0;
  logic         trng_en_o;
  logic         trng_in = 1'b0;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic         error_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  trng_collector #(.WIDTH(W), .WARMUP_CYCLES(4), .REP_LIMIT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_i  (enable_i),
    .trng_en_o (trng_en_o),
    .trng_in   (trng_in),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .error_o   (error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every handshake must deliver the oldest word the stimulus encoded,
  // and an offered word must not change until it is taken.
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [W-1:0] want;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", {63'd0, valid_o}, 64'd1);
        check("hold_data", {56'd0, data_o}, {56'd0, prev_data});
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL xfer_unexpected: got word %0h, expected no word", data_o);
        end else begin
          want = exp_q.pop_front();
          check("xfer_data", {56'd0, data_o}, {56'd0, want});
        end
      end
      prev_hold = valid_o && !ready_i;
      prev_data = data_o;
    end
  end

  // All stimulus changes happen on the falling edge; one call = one raw sample.
  task automatic tick(input logic b);
    trng_in = b;
    @(negedge clk);
  endtask

  task automatic send_pair(input logic b);
    tick(b);
    tick(!b);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit junk);
    exp_q.push_back(w);
    for (int i = W - 1; i >= 0; i--) begin
      if (junk) begin
        tick(i[0]);
        tick(i[0]);
      end
      send_pair(w[i]);
    end
  endtask

  task automatic start();
    enable_i = 1'b1;
    tick(1'b0);
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
  endtask

  task automatic read_word();
    ready_i = 1'b1;
    tick(1'b0);
    ready_i = 1'b0;
    tick(1'b0);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {51'd0, trng_en_o, valid_o, error_o, data_o}, 64'd0);
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_outputs");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle_outputs("idle_outputs");
    end

    // Warm-up discard: warm-up samples are 1,0,1,0 and must not leak
    enable_i = 1'b1;
    check("en_before_edge", {63'd0, trng_en_o}, 64'd0);
    tick(1'b0);
    check("en_after_enable", {63'd0, trng_en_o}, 64'd1);
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
    send_word(8'hA5, 1'b0);
    check("warmup_valid", {63'd0, valid_o}, 64'd1);
    check("warmup_data", {56'd0, data_o}, 64'hA5);
    read_word();
    check("after_read_valid", {63'd0, valid_o}, 64'd0);

    // Discarded 00/11 pairs interleaved
    send_word(8'h3C, 1'b1);
    check("vn_valid", {63'd0, valid_o}, 64'd1);
    check("vn_data", {56'd0, data_o}, 64'h3C);
    read_word();

    // Backpressure: second word waits in STALL
    send_word(8'h11, 1'b0);
    check("bp_first_data", {56'd0, data_o}, 64'h11);
    send_word(8'h22, 1'b0);
    check("bp_stall_data", {56'd0, data_o}, 64'h11);
    check("bp_stall_valid", {63'd0, valid_o}, 64'd1);
    tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
    check("bp_stall_en", {63'd0, trng_en_o}, 64'd1);
    ready_i = 1'b1;
    tick(1'b0);
    ready_i = 1'b0;
    check("bp_next_data", {56'd0, data_o}, 64'h22);
    check("bp_next_valid", {63'd0, valid_o}, 64'd1);
    read_word();
    check("bp_drained", {63'd0, valid_o}, 64'd0);

    // Disable mid-word, including a half pair
    send_pair(1'b1); send_pair(1'b0); send_pair(1'b1); send_pair(1'b1); send_pair(1'b0);
    tick(1'b1);
    enable_i = 1'b0;
    tick(1'b0);
    check("dis_en", {63'd0, trng_en_o}, 64'd0);
    check("dis_valid", {63'd0, valid_o}, 64'd0);
    tick(1'b0); tick(1'b0);
    check("dis_en_idle", {63'd0, trng_en_o}, 64'd0);
    start();
    send_word(8'hFF, 1'b0);
    check("reen_data", {56'd0, data_o}, 64'hFF);
    check("reen_valid", {63'd0, valid_o}, 64'd1);
    read_word();

    // Repetition-count health test
    start();
    for (int i = 0; i < 16; i++) begin
      tick(1'b1);
      check("rep_error", {63'd0, error_o}, {63'd0, HEALTH && (i == 15)});
    end
    check("rep_en", {63'd0, trng_en_o}, {63'd0, !HEALTH});
    check("rep_no_word", {63'd0, valid_o}, 64'd0);
    tick(1'b1); tick(1'b1); tick(1'b1);
    check("rep_sticky", {63'd0, error_o}, {63'd0, HEALTH});
    check("rep_en_held", {63'd0, trng_en_o}, {63'd0, !HEALTH});
    enable_i = 1'b0;
    tick(1'b0);
    check("rep_cleared", {63'd0, error_o}, 64'd0);
    tick(1'b0);
    check("rep_idle_en", {63'd0, trng_en_o}, 64'd0);
    check("queue_empty", exp_q.size(), 64'd0);

    // Asynchronous reset drops a pending word
    start();
    send_word(8'h5A, 1'b0);
    check("pre_reset_valid", {63'd0, valid_o}, 64'd1);
    check("pre_reset_data", {56'd0, data_o}, 64'h5A);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    enable_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0); tick(1'b1);
    check_idle_outputs("post_reset_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
